// File: rtl/clap_detector.sv
`default_nettype none
// ============================================================================
//  Module   : clap_detector
//  Purpose  : Watches an unsigned AXI-Stream audio sample stream for a
//             "clap-clap" pattern: a loud transient followed by a quiet
//             interval, then a second loud transient (within a bounded window)
//             followed by another quiet interval. Each detection toggles the
//             LED output and emits a one-cycle pulse.
//  Ports    : s00_axis_aclk     - clock
//             s00_axis_aresetn  - asynchronous active-low reset
//             s00_axis_tvalid   - sample valid
//             s00_axis_tdata    - unsigned sample (W bits)
//             s00_axis_tstrb    - byte strobes (unused)
//             s00_axis_tready   - always 1 after the first edge out of reset
//             light             - LED state, toggles per detection
//             detect_pulse      - one-cycle pulse per detection
//             busy              - pattern tracking in progress (not IDLE)
//  Revision : 1.0 - initial release
// ============================================================================
module clap_detector #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 16,
  parameter int MIDSCALE               = 2048,
  parameter int THRESHOLD              = 512,
  parameter int QUIET_LEN              = 64,
  parameter int WINDOW_LEN             = 4096
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_aresetn,
  input  logic                                  s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
  output logic                                  s00_axis_tready,
  output logic                                  light,
  output logic                                  detect_pulse,
  output logic                                  busy
);

  localparam int c_W  = C_S00_AXIS_TDATA_WIDTH;
  localparam int c_QW = $clog2(QUIET_LEN + 1);
  localparam int c_EW = $clog2(WINDOW_LEN + 1);

  localparam logic [c_W-1:0]  c_MID       = c_W'(MIDSCALE);
  localparam logic [c_W-1:0]  c_THR       = c_W'(THRESHOLD);
  localparam logic [c_QW-1:0] c_QUIET_MAX = c_QW'(QUIET_LEN);
  localparam logic [c_EW-1:0] c_WIN_MAX   = c_EW'(WINDOW_LEN);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_QUIET1 = 2'd1,
    S_WAIT2  = 2'd2,
    S_QUIET2 = 2'd3
  } state_t;

  // Byte strobes carry no meaning for a single-sample stream.
  logic w_unused;
  assign w_unused = ^s00_axis_tstrb;

  // --------------------------------------------------------------------------
  // Stage 1: accept, magnitude about midscale, loud flag
  // --------------------------------------------------------------------------
  logic           r_tready;
  logic           r_s1_valid;
  logic           r_s1_loud;
  logic           w_accept;
  logic [c_W-1:0] w_amp;

  assign w_accept = s00_axis_tvalid && r_tready;

  // Subtract in whichever order keeps the result non-negative, so neither
  // extreme code (0 or all-ones) can wrap.
  assign w_amp = (s00_axis_tdata >= c_MID) ? (s00_axis_tdata - c_MID)
                                           : (c_MID - s00_axis_tdata);

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_tready   <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_loud  <= 1'b0;
    end else begin
      r_tready   <= 1'b1;
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_loud <= (w_amp >= c_THR);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: pattern FSM, advances only on stage-1 valid
  // --------------------------------------------------------------------------
  state_t          r_state;
  logic [c_QW-1:0] r_qcnt;
  logic [c_EW-1:0] r_ecnt;
  logic            r_light;
  logic            r_pulse;
  logic            r_busy;
  logic [c_QW-1:0] w_qcnt_inc;
  logic [c_EW-1:0] w_ecnt_inc;
  logic            w_q_done;
  logic            w_e_done;

  assign w_qcnt_inc = r_qcnt + c_QW'(1);
  assign w_ecnt_inc = r_ecnt + c_EW'(1);
  // Counts "reached" on the sample being processed, i.e. after increment.
  assign w_q_done   = !r_s1_loud && (w_qcnt_inc == c_QUIET_MAX);
  assign w_e_done   = (w_ecnt_inc == c_WIN_MAX);

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_state <= S_IDLE;
      r_qcnt  <= '0;
      r_ecnt  <= '0;
      r_light <= 1'b0;
      r_pulse <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      // Pulse lasts one clock regardless of how soon the next sample comes.
      r_pulse <= 1'b0;
      if (r_s1_valid) begin
        case (r_state)
          S_IDLE: begin
            if (r_s1_loud) begin
              r_state <= S_QUIET1;
              r_busy  <= 1'b1;
              r_qcnt  <= '0;
              r_ecnt  <= '0;
            end
          end
          S_QUIET1, S_QUIET2: begin
            r_ecnt <= w_ecnt_inc;
            r_qcnt <= r_s1_loud ? '0 : w_qcnt_inc;
            // A completed quiet run wins over a window expiry on the same sample.
            if (w_q_done) begin
              if (r_state == S_QUIET1) begin
                r_state <= S_WAIT2;
                r_ecnt  <= '0;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_light <= ~r_light;
                r_pulse <= 1'b1;
              end
            end else if (w_e_done) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
          S_WAIT2: begin
            r_ecnt <= w_ecnt_inc;
            // A second clap is honoured even on the last sample of the window.
            if (r_s1_loud) begin
              r_state <= S_QUIET2;
              r_qcnt  <= '0;
              r_ecnt  <= '0;
            end else if (w_e_done) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign s00_axis_tready = r_tready;
  assign light           = r_light;
  assign detect_pulse    = r_pulse;
  assign busy            = r_busy;

endmodule
`default_nettype wire
